// File: rtl/mem_arbiter_if.sv
// Bus bundle for the unified-memory arbiter: the fetch port, the load/store
// port, the single-port memory port and the busy flag.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding core and memory, which drive requests and responses.
interface mem_arbiter_if #(
  parameter int DWIDTH = 32
);

  // Instruction-fetch requester
  logic              if_req;
  logic [DWIDTH-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [DWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic [2:0]        d_type;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DWIDTH-1:0] d_rdata;

  // Single-port memory
  logic              mem_req;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [2:0]        mem_type;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DWIDTH-1:0] mem_rdata;

  // Arbiter status
  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_type,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_type,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter that lets the rv32i fetch path and load/store path share one
// single-port memory. One transaction is in flight at a time; data accesses
// win ties, except that a streak counter forces a fetch through after
// STARVE_LIMIT consecutive data grants while a fetch was waiting.
// A fetch whose result became stale (taken branch/jump) can be flushed: the
// memory access still completes but the response is dropped.
module mem_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  localparam logic [2:0] TYPE_WORD  = 3'b010;

  state_e            state_q,    state_d;
  owner_e            owner_q,    owner_d;
  logic [DWIDTH-1:0] addr_q,     addr_d;
  logic              we_q,       we_d;
  logic [DWIDTH-1:0] wdata_q,    wdata_d;
  logic [2:0]        type_q,     type_d;
  logic [3:0]        streak_q,   streak_d;
  logic              kill_q,     kill_d;
  logic              ifRvalid_q, ifRvalid_d;
  logic [DWIDTH-1:0] ifRdata_q,  ifRdata_d;
  logic              dRvalid_q,  dRvalid_d;
  logic [DWIDTH-1:0] dRdata_q,   dRdata_d;

  logic gntIf;
  logic gntD;
  logic dropFetch;

  // Grant selection: only in IDLE and never while reset is held. Data wins a
  // tie unless the fetch side has already waited out a full streak.
  always_comb begin
    gntIf = 1'b0;
    gntD  = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (bus.d_req && bus.if_req) begin
        if (streak_q == STREAK_MAX) begin
          gntIf = 1'b1;
        end else begin
          gntD = 1'b1;
        end
      end else if (bus.d_req) begin
        gntD = 1'b1;
      end else if (bus.if_req) begin
        gntIf = 1'b1;
      end
    end
  end

  // A fetch response is dropped if a flush was seen earlier in the
  // transaction or arrives together with the response itself.
  always_comb begin
    dropFetch = kill_q || bus.if_flush;
  end

  // Next-state logic: latch the winner in IDLE, hold the memory request in
  // ISSUE until accepted, and route the response to its owner from WAIT.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    type_d     = type_q;
    streak_d   = streak_q;
    kill_d     = kill_q;
    ifRvalid_d = 1'b0;
    ifRdata_d  = ifRdata_q;
    dRvalid_d  = 1'b0;
    dRdata_d   = dRdata_q;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (gntD) begin
          state_d = ISSUE;
          owner_d = OWN_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_we;
          wdata_d = bus.d_wdata;
          type_d  = bus.d_type;
          if (bus.if_req) begin
            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end else if (gntIf) begin
          state_d  = ISSUE;
          owner_d  = OWN_IF;
          addr_d   = bus.if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          type_d   = TYPE_WORD;
          streak_d = 4'd0;
        end
      end

      ISSUE: begin
        if (owner_q == OWN_IF && bus.if_flush) begin
          kill_d = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (owner_q == OWN_IF && bus.if_flush) begin
          kill_d = 1'b1;
        end
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          kill_d  = 1'b0;
          if (owner_q == OWN_D) begin
            dRvalid_d = 1'b1;
            dRdata_d  = we_q ? '0 : bus.mem_rdata;
          end else if (!dropFetch) begin
            ifRvalid_d = 1'b1;
            ifRdata_d  = bus.mem_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so every output
  // reads zero in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      type_q     <= 3'b000;
      streak_q   <= 4'd0;
      kill_q     <= 1'b0;
      ifRvalid_q <= 1'b0;
      ifRdata_q  <= '0;
      dRvalid_q  <= 1'b0;
      dRdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      type_q     <= type_d;
      streak_q   <= streak_d;
      kill_q     <= kill_d;
      ifRvalid_q <= ifRvalid_d;
      ifRdata_q  <= ifRdata_d;
      dRvalid_q  <= dRvalid_d;
      dRdata_q   <= dRdata_d;
    end
  end

  assign bus.if_gnt    = gntIf;
  assign bus.d_gnt     = gntD;
  assign bus.if_rvalid = ifRvalid_q;
  assign bus.if_rdata  = ifRdata_q;
  assign bus.d_rvalid  = dRvalid_q;
  assign bus.d_rdata   = dRdata_q;
  assign bus.mem_req   = (state_q == ISSUE);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_type  = type_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector tables for single
// transactions, stalls, flush and reset, plus a hand-written sequence for the
// starvation guard under continuous contention.
module tb_mem_arbiter;

  localparam logic [2:0] W = 3'b010;
  localparam logic [31:0] R1 = 32'h0051_3093;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifFlush;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [2:0]  dType;
    logic        memReady;
    logic        memRvalid;
    logic [31:0] memRdata;
  } in_t;

  typedef struct {
    logic        ifGnt;
    logic        dGnt;
    logic        ifRvalid;
    logic [31:0] ifRdata;
    logic        dRvalid;
    logic [31:0] dRdata;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [2:0]  memType;
    logic        busy;
  } exp_t;

  typedef struct {
    in_t  stim;
    exp_t exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[$];

  mem_arbiter_if #(.DWIDTH(32)) bus ();

  mem_arbiter #(
    .DWIDTH(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic in_t mkIn(logic r, logic ir, logic [31:0] ia, logic fl, logic dr, logic dw,
                               logic [31:0] da, logic [31:0] dd, logic [2:0] dt,
                               logic mr, logic mv, logic [31:0] md);
    in_t s;
    s.rst = r; s.ifReq = ir; s.ifAddr = ia; s.ifFlush = fl;
    s.dReq = dr; s.dWe = dw; s.dAddr = da; s.dWdata = dd; s.dType = dt;
    s.memReady = mr; s.memRvalid = mv; s.memRdata = md;
    return s;
  endfunction

  function automatic exp_t mkExp(logic ig, logic dg, logic iv, logic [31:0] id, logic dv,
                                 logic [31:0] dd, logic mq, logic mw, logic [31:0] ma,
                                 logic [31:0] mwd, logic [2:0] mt, logic b);
    exp_t e;
    e.ifGnt = ig; e.dGnt = dg; e.ifRvalid = iv; e.ifRdata = id;
    e.dRvalid = dv; e.dRdata = dd; e.memReq = mq; e.memWe = mw;
    e.memAddr = ma; e.memWdata = mwd; e.memType = mt; e.busy = b;
    return e;
  endfunction

  task automatic addVec(input in_t s, input exp_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input in_t s);
    rst          = s.rst;
    bus.if_req   = s.ifReq;
    bus.if_addr  = s.ifAddr;
    bus.if_flush = s.ifFlush;
    bus.d_req    = s.dReq;
    bus.d_we     = s.dWe;
    bus.d_addr   = s.dAddr;
    bus.d_wdata  = s.dWdata;
    bus.d_type   = s.dType;
    bus.mem_ready  = s.memReady;
    bus.mem_rvalid = s.memRvalid;
    bus.mem_rdata  = s.memRdata;
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    chk({tag, ".if_gnt"},    32'(bus.if_gnt),    32'(e.ifGnt));
    chk({tag, ".d_gnt"},     32'(bus.d_gnt),     32'(e.dGnt));
    chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(e.ifRvalid));
    chk({tag, ".if_rdata"},  bus.if_rdata,       e.ifRdata);
    chk({tag, ".d_rvalid"},  32'(bus.d_rvalid),  32'(e.dRvalid));
    chk({tag, ".d_rdata"},   bus.d_rdata,        e.dRdata);
    chk({tag, ".mem_req"},   32'(bus.mem_req),   32'(e.memReq));
    chk({tag, ".mem_we"},    32'(bus.mem_we),    32'(e.memWe));
    chk({tag, ".mem_addr"},  bus.mem_addr,       e.memAddr);
    chk({tag, ".mem_wdata"}, bus.mem_wdata,      e.memWdata);
    chk({tag, ".mem_type"},  32'(bus.mem_type),  32'(e.memType));
    chk({tag, ".busy"},      32'(bus.busy),      32'(e.busy));
  endtask

  // Drive each vector at the falling edge, check 1 unit later, then clear
  // the table so it can be refilled for the next phase.
  task automatic runVecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].stim);
      #1;
      checkOutput(vecs[i].exp, $sformatf("%s[%0d]", tag, i));
    end
    vecs.delete();
  endtask

  // Main test sequence
  initial begin
    logic isIfExp [10];
    int   cyc;
    int   lastCyc;
    int   waitCnt;
    bit   found;

    checks = 0;
    errors = 0;
    applyStimulus(mkIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);

    // Reset state, single fetch with 1-cycle ready and immediate response
    addVec(mkIn(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0),  mkExp(0, 0, 0, 0,  0, 0, 0, 0, 0,     0, 0, 0));
    addVec(mkIn(0, 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkExp(1, 0, 0, 0,  0, 0, 0, 0, 0,     0, 0, 0));
    addVec(mkIn(0, 0, 0,     0, 0, 0, 0, 0, 0, 1, 0, 0),  mkExp(0, 0, 0, 0,  0, 0, 1, 0, 32'h10, 0, W, 1));
    addVec(mkIn(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 1, R1), mkExp(0, 0, 0, 0,  0, 0, 0, 0, 32'h10, 0, W, 1));
    addVec(mkIn(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0),  mkExp(0, 0, 1, R1, 0, 0, 0, 0, 32'h10, 0, W, 0));
    // Store with three stall cycles on mem_ready; write response data ignored
    addVec(mkIn(0, 0, 0, 0, 1, 1, 32'h100, DB, W, 0, 0, 0), mkExp(0, 1, 0, R1, 0, 0, 0, 0, 32'h10,  0,  W, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),        mkExp(0, 0, 0, R1, 0, 0, 1, 1, 32'h100, DB, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),        mkExp(0, 0, 0, R1, 0, 0, 1, 1, 32'h100, DB, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),        mkExp(0, 0, 0, R1, 0, 0, 1, 1, 32'h100, DB, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),        mkExp(0, 0, 0, R1, 0, 0, 1, 1, 32'h100, DB, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),        mkExp(0, 0, 0, R1, 0, 0, 0, 1, 32'h100, DB, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555), mkExp(0, 0, 0, R1, 0, 0, 0, 1, 32'h100, DB, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),        mkExp(0, 0, 0, R1, 1, 0, 0, 1, 32'h100, DB, W, 0));
    // Unsigned-byte load, response cycle coincides with a new fetch grant
    addVec(mkIn(0, 0, 0, 0, 1, 0, 32'h200, 0, 3'b100, 0, 0, 0), mkExp(0, 1, 0, R1, 0, 0, 0, 1, 32'h100, DB, W, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),            mkExp(0, 0, 0, R1, 0, 0, 1, 0, 32'h200, 0, 3'b100, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFF),       mkExp(0, 0, 0, R1, 0, 0, 0, 0, 32'h200, 0, 3'b100, 1));
    addVec(mkIn(0, 1, 32'h14, 0, 0, 0, 0, 0, 0, 0, 0, 0),       mkExp(1, 0, 0, R1, 1, 32'hFF, 0, 0, 32'h200, 0, 3'b100, 0));
    // Flushed fetch, then a fetch granted while if_flush is high in IDLE
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),             mkExp(0, 0, 0, R1, 0, 32'hFF, 1, 0, 32'h14, 0, W, 1));
    addVec(mkIn(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),             mkExp(0, 0, 0, R1, 0, 32'hFF, 0, 0, 32'h14, 0, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678), mkExp(0, 0, 0, R1, 0, 32'hFF, 0, 0, 32'h14, 0, W, 1));
    addVec(mkIn(0, 1, 32'h18, 1, 0, 0, 0, 0, 0, 0, 0, 0),        mkExp(1, 0, 0, R1, 0, 32'hFF, 0, 0, 32'h14, 0, W, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),             mkExp(0, 0, 0, R1, 0, 32'hFF, 1, 0, 32'h18, 0, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13),        mkExp(0, 0, 0, R1, 0, 32'hFF, 0, 0, 32'h18, 0, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),             mkExp(0, 0, 1, 32'h13, 0, 32'hFF, 0, 0, 32'h18, 0, W, 0));
    runVecs("basic");

    // Continuous contention: with limit 4 the fetch side gets every fifth
    // grant, and grants are spaced 3 cycles apart. mem_rvalid is held high
    // throughout, so it is also seen (and must be ignored) in IDLE and ISSUE.
    isIfExp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    applyStimulus(mkIn(0, 1, 32'h40, 0, 1, 0, 32'h300, 0, W, 1, 1, 32'h55));
    cyc     = 0;
    lastCyc = 0;
    for (int g = 0; g < 10; g++) begin
      found   = 1'b0;
      waitCnt = 0;
      while (!found && waitCnt < 8) begin
        #1;
        if (bus.if_gnt || bus.d_gnt) begin
          found = 1'b1;
          chk($sformatf("starve[%0d].if_gnt", g), 32'(bus.if_gnt), 32'(isIfExp[g]));
          chk($sformatf("starve[%0d].d_gnt", g),  32'(bus.d_gnt),  32'(!isIfExp[g]));
          if (g > 0) begin
            chk($sformatf("starve[%0d].gap", g), 32'(cyc - lastCyc), 32'd3);
          end
          lastCyc = cyc;
        end
        @(negedge clk);
        cyc++;
        waitCnt++;
      end
      if (!found) begin
        checks++;
        errors++;
        $display("[TB] FAIL starve[%0d].grant actual=none required=grant within 8 cycles", g);
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) @(negedge clk);
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;

    // Reset during WAIT: late response ignored, everything cleared, grants
    // suppressed while reset is held, normal fetch afterwards
    addVec(mkIn(0, 0, 0, 0, 1, 0, 32'h400, 0, W, 0, 0, 0),   mkExp(0, 1, 0, 32'h55, 0, 32'h55, 0, 0, 32'h40,  0, W, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),         mkExp(0, 0, 0, 32'h55, 0, 32'h55, 1, 0, 32'h400, 0, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),         mkExp(0, 0, 0, 32'h55, 0, 32'h55, 0, 0, 32'h400, 0, W, 1));
    addVec(mkIn(1, 1, 32'h24, 0, 1, 0, 32'h404, 0, W, 0, 0, 0), mkExp(0, 0, 0, 32'h55, 0, 32'h55, 0, 0, 32'h400, 0, W, 1));
    addVec(mkIn(1, 1, 32'h24, 0, 1, 0, 32'h404, 0, W, 0, 0, 0), mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE),  mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),         mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 1, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0),    mkExp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),         mkExp(0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0010_0093), mkExp(0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 0, W, 1));
    addVec(mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),         mkExp(0, 0, 1, 32'h0010_0093, 0, 0, 0, 0, 32'h20, 0, W, 0));
    runVecs("reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
